// File: rtl/mvm_arbiter.sv
// Shares one matrix-vector engine among N requesters: round-robin job grant,
// operand streaming, bounded wait for completion and result draining.
module mvm_arbiter #(
   parameter int K       = 12,
   parameter int B       = 20,
   parameter int N       = 2,
   parameter int TIMEOUT = 255,
   localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mat_reuse,
   input  logic [N*B-1:0]   src_data,
   output logic [N-1:0]     grant,
   output logic [N-1:0]     src_pop,
   output logic             loadMatrix,
   output logic             loadVector,
   output logic             start,
   output logic [B-1:0]     data_in,
   input  logic             done,
   input  logic [2*B-1:0]   data_out,
   output logic             res_valid,
   output logic [2*B-1:0]   res_data,
   output logic [IW-1:0]    res_id,
   output logic             res_last,
   output logic             err
);

   localparam int CMAX = (K * K > TIMEOUT) ? K * K : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_M,
      S_LOAD_V,
      S_START,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_owner;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_mat_owner;
   logic          r_mat_vld;
   logic [N-1:0]  r_grant;
   logic [N-1:0]  r_src_pop;
   logic          r_load_m;
   logic          r_load_v;
   logic          r_start;
   logic          r_res_valid;
   logic          r_res_last;
   logic          r_err;

   logic          w_found;
   logic [IW-1:0] w_win;
   logic [IW-1:0] w_ptr_next;
   logic          w_reuse;
   logic [B-1:0]  w_word;

   // Search starts at r_ptr, the index just after the last winner.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && req[(int'(r_ptr) + k) % N]) begin
            w_found = 1'b1;
            w_win   = IW'((int'(r_ptr) + k) % N);
         end
      end
   end

   assign w_ptr_next = (int'(w_win) == N - 1) ? '0 : w_win + IW'(1);
   assign w_reuse    = mat_reuse[w_win] && r_mat_vld && (r_mat_owner == w_win);
   assign w_word     = src_data[int'(r_owner) * B +: B];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_owner     <= '0;
         r_ptr       <= '0;
         r_mat_owner <= '0;
         r_mat_vld   <= 1'b0;
         r_grant     <= '0;
         r_src_pop   <= '0;
         r_load_m    <= 1'b0;
         r_load_v    <= 1'b0;
         r_start     <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_last  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= N'(1) << w_win;
                  r_owner <= w_win;
                  r_ptr   <= w_ptr_next;
                  r_cnt   <= '0;
                  if (w_reuse) begin
                     r_state  <= S_LOAD_V;
                     r_load_v <= 1'b1;
                  end else begin
                     r_state  <= S_LOAD_M;
                     r_load_m <= 1'b1;
                  end
               end
            end
            S_LOAD_M: begin
               r_load_m <= 1'b0;
               if (r_cnt == CW'(K * K)) begin
                  r_src_pop   <= '0;
                  r_load_v    <= 1'b1;
                  r_cnt       <= '0;
                  r_mat_vld   <= 1'b1;
                  r_mat_owner <= r_owner;
                  r_state     <= S_LOAD_V;
               end else begin
                  r_src_pop <= r_grant;
                  r_cnt     <= r_cnt + CW'(1);
               end
            end
            S_LOAD_V: begin
               r_load_v <= 1'b0;
               if (r_cnt == CW'(K)) begin
                  r_src_pop <= '0;
                  r_start   <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= S_START;
               end else begin
                  r_src_pop <= r_grant;
                  r_cnt     <= r_cnt + CW'(1);
               end
            end
            S_START: begin
               r_start <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (done) begin
                  r_state     <= S_DRAIN;
                  r_res_valid <= 1'b1;
                  r_res_last  <= (K == 1);
                  r_cnt       <= CW'(1);
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  // The engine state is unknown after a hang, so the resident matrix is distrusted.
                  r_err     <= 1'b1;
                  r_mat_vld <= 1'b0;
                  r_grant   <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DRAIN: begin
               if (r_cnt == CW'(K)) begin
                  r_res_valid <= 1'b0;
                  r_res_last  <= 1'b0;
                  r_grant     <= '0;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt      <= r_cnt + CW'(1);
                  r_res_last <= (r_cnt == CW'(K - 1));
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant      = r_grant;
   assign src_pop    = r_src_pop;
   assign loadMatrix = r_load_m;
   assign loadVector = r_load_v;
   assign start      = r_start;
   assign data_in    = (|r_src_pop) ? w_word : '0;
   assign res_valid  = r_res_valid;
   assign res_data   = r_res_valid ? data_out : '0;
   assign res_id     = r_res_valid ? r_owner : '0;
   assign res_last   = r_res_last;
   assign err        = r_err;

endmodule

// File: tb/tb_mvm_arbiter.sv
// Directed bench for mvm_arbiter: round-robin order, load sequencing and
// latency, matrix reuse, timeout recovery and asynchronous reset.
module tb_mvm_arbiter;

   localparam int K  = 12;
   localparam int B  = 20;
   localparam int N  = 2;
   localparam int TO = 255;
   localparam logic [B-1:0] W0 = 20'h1A2B3;
   localparam logic [B-1:0] W1 = 20'hC4D5E;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   mat_reuse;
   logic [N*B-1:0] src_data;
   logic [N-1:0]   grant;
   logic [N-1:0]   src_pop;
   logic           loadMatrix;
   logic           loadVector;
   logic           start;
   logic [B-1:0]   data_in;
   logic           done;
   logic [2*B-1:0] data_out;
   logic           res_valid;
   logic [2*B-1:0] res_data;
   logic [0:0]     res_id;
   logic           res_last;
   logic           err;
   logic [70:0]    outs;

   int n_cmp = 0;
   int n_bad = 0;

   mvm_arbiter #(.K(K), .B(B), .N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .mat_reuse(mat_reuse),
      .src_data(src_data), .grant(grant), .src_pop(src_pop),
      .loadMatrix(loadMatrix), .loadVector(loadVector), .start(start),
      .data_in(data_in), .done(done), .data_out(data_out),
      .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
      .res_last(res_last), .err(err)
   );

   always #5 clk = ~clk;

   assign outs = {grant, src_pop, loadMatrix, loadVector, start, data_in,
                  res_valid, res_data, res_id, res_last, err};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one job from the first cycle after the request is visible to IDLE.
   // done_d = 0 withholds done so the job must time out.
   task automatic run_job(input string name, input logic [N-1:0] exp_grant, input bit full,
                          input int exp_first, input int done_d, input bit drop_req,
                          input bit stray_done, input logic exp_err);
      logic [B-1:0] exp_word;
      logic         exp_id;
      logic [N-1:0] g_first = '0;
      int  lm_n = 0, lv_n = 0, st_n = 0, popm = 0, popv = 0;
      int  rv_n = 0, last_n = 0, last_at = 0;
      int  first_c = 0, st_c = 0, err_c = 0;
      int  excl_bad = 0, data_bad = 0, grant_bad = 0, res_bad = 0;
      bit  finished = 0;
      exp_word = exp_grant[1] ? W1 : W0;
      exp_id   = exp_grant[1];
      for (int c = 1; c <= 700; c++) begin
         @(negedge clk);
         if (done_d == 0 && st_n > 0 && err === 1'b1) begin
            err_c    = c;
            finished = 1;
            check({name, ".grant_after_timeout"}, grant, '0);
            break;
         end
         if (int'(loadMatrix) + int'(loadVector) + int'(start) + int'(|src_pop) > 1) excl_bad++;
         if (src_pop === '0 && data_in !== '0) excl_bad++;
         if ((loadMatrix || loadVector) && first_c == 0) begin
            first_c = c;
            g_first = grant;
         end
         if (first_c != 0 && grant !== exp_grant) grant_bad++;
         if (loadMatrix) lm_n++;
         if (loadVector) lv_n++;
         if (src_pop !== '0) begin
            if (lv_n == 0) popm++;
            else popv++;
            if (src_pop !== exp_grant || data_in !== exp_word) data_bad++;
         end
         if (start) begin
            st_n++;
            if (st_c == 0) st_c = c;
         end
         if (res_valid) begin
            rv_n++;
            if (res_id !== exp_id || res_data !== data_out) res_bad++;
            if (res_last) begin
               last_n++;
               last_at = rv_n;
            end
         end else if (res_last) begin
            res_bad++;
         end
         if (res_last === 1'b1) begin
            finished = 1;
            break;
         end
         data_out = {8'hA5, 32'(c)};
         if (drop_req && c == 3) req = '0;
         done = 1'b0;
         if (stray_done && first_c != 0 && c == first_c + 20) done = 1'b1;
         if (done_d > 0 && st_c != 0 && c == st_c + done_d) done = 1'b1;
      end
      done = 1'b0;
      check({name, ".finished"}, finished, 1);
      check({name, ".grant"}, g_first, exp_grant);
      check({name, ".first_pulse_cycle"}, first_c, exp_first);
      check({name, ".loadMatrix_pulses"}, lm_n, full ? 1 : 0);
      check({name, ".matrix_pops"}, popm, full ? K * K : 0);
      check({name, ".loadVector_pulses"}, lv_n, 1);
      check({name, ".vector_pops"}, popv, K);
      check({name, ".start_cycle"}, st_c, exp_first + (full ? K * K + K + 2 : K + 1));
      check({name, ".start_pulses"}, st_n, 1);
      check({name, ".exclusive_strobes"}, excl_bad, 0);
      check({name, ".pop_data"}, data_bad, 0);
      check({name, ".grant_held"}, grant_bad, 0);
      if (done_d > 0) begin
         check({name, ".result_words"}, rv_n, K);
         check({name, ".last_count"}, last_n, 1);
         check({name, ".last_position"}, last_at, K);
         check({name, ".result_fields"}, res_bad, 0);
      end else begin
         check({name, ".timeout_cycle"}, err_c, st_c + TO + 1);
         check({name, ".no_results"}, rv_n, 0);
      end
      check({name, ".err"}, err, exp_err);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops;
      reset     = 1'b0;
      req       = '0;
      mat_reuse = '0;
      src_data  = {W1, W0};
      done      = 1'b0;
      data_out  = '0;
      @(negedge clk);
      check("reset_outputs", outs, '0);
      req = 2'b11;
      @(negedge clk);
      check("reset_outputs_with_req", outs, '0);
      reset = 1'b1;

      // Both requesters held from reset: strict alternation starting at index 0.
      run_job("rr_job1", 2'b01, 1, 1, 5, 0, 1, 1'b0);
      run_job("rr_job2", 2'b10, 1, 2, 7, 0, 0, 1'b0);
      run_job("rr_job3", 2'b01, 1, 2, 3, 0, 0, 1'b0);
      req = '0;
      @(negedge clk);
      check("idle_grant", grant, '0);

      req = 2'b01; mat_reuse = 2'b01;
      run_job("reuse_r0", 2'b01, 0, 1, 4, 1, 0, 1'b0);
      @(negedge clk);
      req = 2'b10; mat_reuse = 2'b10;
      run_job("reuse_r1_not_owner", 2'b10, 1, 1, 2, 1, 0, 1'b0);
      @(negedge clk);
      req = 2'b10; mat_reuse = 2'b10;
      run_job("timeout_r1", 2'b10, 0, 1, 0, 1, 0, 1'b1);
      req = 2'b10; mat_reuse = 2'b10;
      run_job("after_timeout_r1", 2'b10, 1, 1, 6, 1, 0, 1'b1);

      // Abandon a matrix load part way through with reset.
      @(negedge clk);
      req = 2'b01; mat_reuse = 2'b00;
      pops = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (src_pop[0]) pops++;
         if (pops == 50) break;
      end
      check("reach_word50", pops, 50);
      reset = 1'b0;
      #1;
      check("reset_async_outputs", outs, '0);
      req = '0;
      @(negedge clk);
      check("reset_hold_outputs", outs, '0);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_reset_quiet", outs, '0);
      end
      req = 2'b10; mat_reuse = 2'b10;
      run_job("post_reset_r1", 2'b10, 1, 1, 5, 1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mvm_arbiter.md
MVM_ARBITER -- requirements
Module: mvm_arbiter

Interface
REQ-001 SHALL have parameters: K, default 12, matrix dimension; B, default 20, input word width; N, default 2, requester count; TIMEOUT, default 255, max WAIT cycles.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req  in  N  per-requester job request.
- mat_reuse  in  N  skip matrix load if that requester owns the resident matrix.
- src_data  in  N*B  per-requester operand word.
- grant  out  N  one-hot job owner.
- src_pop  out  N  granted requester's word consumed this cycle.
- loadMatrix  out  1  engine matrix-load pulse.
- loadVector  out  1  engine vector-load pulse.
- start  out  1  engine compute pulse.
- data_in  out  B  engine operand word.
- done  in  1  engine completion pulse.
- data_out  in  2B  engine result word.
- res_valid  out  1  result word valid.
- res_data  out  2B  result word.
- res_id  out  log2(N), min 1  result owner index.
- res_last  out  1  final result word of job.
- err  out  1  sticky timeout flag.

Function
REQ-003 SHALL sequence states IDLE -> LOAD_M -> LOAD_V -> START -> WAIT -> DRAIN -> IDLE.
REQ-004 IDLE with any req high SHALL pick one requester round-robin, starting after the last-granted index (index 0 first after reset).
REQ-005 grant SHALL register on that edge and hold one-hot through DRAIN; req deassertion mid-job SHALL be ignored.
REQ-006 LOAD_M SHALL be skipped (IDLE -> LOAD_V) when mat_reuse of winner is high, the resident-matrix valid flag is set, and the resident owner equals the winner.
REQ-007 LOAD_M: cycle 0 loadMatrix=1; cycles 1..K*K src_pop[owner]=1 and data_in=src_data[owner]; then LOAD_V.
REQ-008 LOAD_M completion SHALL set the resident-matrix valid flag and record the owner.
REQ-009 LOAD_V: cycle 0 loadVector=1; cycles 1..K src_pop and data_in as REQ-007; then START.
REQ-010 START SHALL assert start for exactly one cycle, then enter WAIT.
REQ-011 WAIT SHALL count cycles; done high -> DRAIN next cycle.
REQ-012 WAIT count reaching TIMEOUT without done -> set err, clear resident flag, drop grant, go IDLE.
REQ-013 DRAIN: for K cycles res_valid=1, res_data=data_out (same cycle), res_id=owner, res_last=1 on the K-th only; then IDLE.
REQ-014 loadMatrix, loadVector, start, src_pop SHALL never be high simultaneously; data_in SHALL be 0 when no src_pop.
REQ-015 done outside WAIT SHALL be ignored.
REQ-016 Latency: req in IDLE at cycle t -> loadMatrix at t+1, start at t+1+K*K+1+K+1 (t+159 at K=12); t+14 with reuse.
REQ-017 A new job SHALL be accepted in the cycle following DRAIN exit (IDLE one cycle minimum).

Reset
REQ-018 reset low SHALL immediately force IDLE, all outputs 0, counters 0, resident flag cleared, round-robin pointer to index 0, err cleared.
REQ-019 reset mid-job SHALL abandon it; no further pulses or results emitted.

Verification
REQ-020 req=01, mat_reuse=00 -> loadMatrix at +1, 144 pops, loadVector, 12 pops, start at +159; done -> 12 res_valid, res_id=0, res_last on 12th.
REQ-021 req=11 held from reset -> grants 01, 10, 01 in order for three consecutive jobs.
REQ-022 Requester 0 job, then requester 0 with mat_reuse=1 -> second job has no loadMatrix, start 14 cycles after req; requester 1 with mat_reuse=1 -> full load.
REQ-023 done withheld -> err=1 after 255 WAIT cycles, grant=0, next req served with full matrix load.
REQ-024 reset low during LOAD_M word 50 -> all outputs 0 same cycle; after release, a reuse request performs full load.
